ika9958_tile_fetch_seq: RTL and testbench

Slot-driven VRAM fetch sequencer that consumes the registered common-PLA-counter decodes (modulo-8/modulo-16 slot strobes) and turns them into name-table, pattern-generator and colour-table read requests for one background tile per 8-slot group. It sits between the PLA counter and the VRAM arbiter, and hands a completed pattern/colour byte pair to the background pixel shifter once per tile.

---
 rtl/ika9958_tile_fetch_seq.sv | 137 +++++++++++++
 tb/tb_ika9958_tile_fetch_seq.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/ika9958_tile_fetch_seq.sv
// ika9958_tile_fetch_seq: turns PLA slot strobes into name/pattern/colour VRAM reads,
// one background tile per 8-slot group, and hands the finished byte pair to the shifter.
module ika9958_tile_fetch_seq #(
  parameter int MISS_W = 8
) (
  input  logic              phiA,
  input  logic              RST_async_n,
  input  logic              phiL_NCEN,
  input  logic [3:0]        cpc_z,
  input  logic [7:0]        cpc_m8c,
  input  logic [3:0]        cpc_m16c,
  input  logic              tmode,
  input  logic              disp_en,
  input  logic [6:0]        nt_base,
  input  logic [5:0]        pg_base,
  input  logic [11:0]       ct_base,
  input  logic [4:0]        tile_row,
  input  logic [2:0]        pix_row,
  input  logic              vram_ack,
  input  logic [7:0]        vram_rdata,
  output logic              vram_req,
  output logic [16:0]       vram_addr,
  output logic [7:0]        tile_pat,
  output logic [7:0]        tile_col,
  output logic              tile_vld,
  output logic [MISS_W-1:0] miss_cnt
);
  typedef enum logic [1:0] {IDLE, NAME, PAT, COL} state_t;
  state_t state_q, state_d, start_st;
  logic [4:0] col_idx_q, col_idx_d;
  logic [7:0] name_q, name_d, pat_q, pat_d, col_q, col_d;
  logic [7:0] tile_pat_q, tile_pat_d, tile_col_q, tile_col_d;
  logic name_v_q, name_v_d, pat_v_q, pat_v_d, col_v_q, col_v_d, tile_vld_q, tile_vld_d;
  logic [16:0] addr_q, addr_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic ack, pend;
  logic unused_dbg;
  assign unused_dbg = ^{cpc_z, cpc_m16c};
  always_comb begin
    state_d = state_q;
    col_idx_d = col_idx_q;
    name_d = name_q;
    pat_d = pat_q;
    col_d = col_q;
    name_v_d = name_v_q;
    pat_v_d = pat_v_q;
    col_v_d = col_v_q;
    tile_pat_d = tile_pat_q;
    tile_col_d = tile_col_q;
    tile_vld_d = 1'b0;
    miss_d = miss_q;
    ack = vram_ack && state_q != IDLE;
    pend = state_q != IDLE && !vram_ack;
    start_st = cpc_m8c[0] ? NAME : cpc_m8c[2] ? PAT : (cpc_m8c[4] && !tmode) ? COL : IDLE;
    if (!disp_en) begin
      state_d = IDLE;
      col_idx_d = '0;
      name_v_d = 1'b0;
      pat_v_d = 1'b0;
      col_v_d = 1'b0;
    end else begin
      if (ack) begin
        state_d = IDLE;
        if (state_q == NAME) begin
          name_d = vram_rdata;
          name_v_d = 1'b1;
          col_idx_d = col_idx_q + 5'd1;
        end
        if (state_q == PAT) begin
          pat_d = vram_rdata;
          pat_v_d = name_v_q;
        end
        if (state_q == COL) begin
          col_d = vram_rdata;
          col_v_d = 1'b1;
        end
      end
      // a new slot (or end of group) abandons whatever is still outstanding
      if (start_st != IDLE || cpc_m8c[7]) begin
        state_d = start_st;
        if (pend && !(&miss_q)) miss_d = miss_q + MISS_W'(1);
      end
      if (start_st == NAME) begin
        name_v_d = 1'b0;
        pat_v_d = 1'b0;
        col_v_d = 1'b0;
      end
      if (cpc_m8c[7] && name_v_d && pat_v_d && (col_v_d || tmode)) begin
        tile_vld_d = 1'b1;
        tile_pat_d = pat_d;
        tile_col_d = tmode ? 8'h00 : col_d;
      end
    end
    addr_d = !disp_en ? addr_q :
             start_st == NAME ? {nt_base, tile_row, col_idx_d} :
             start_st == PAT  ? {pg_base, name_d, pix_row} :
             start_st == COL  ? {ct_base, name_d[7:3]} : addr_q;
  end
  always_ff @(posedge phiA or negedge RST_async_n) begin
    if (!RST_async_n) begin
      state_q <= IDLE;
      col_idx_q <= '0;
      name_q <= '0;
      pat_q <= '0;
      col_q <= '0;
      name_v_q <= 1'b0;
      pat_v_q <= 1'b0;
      col_v_q <= 1'b0;
      tile_pat_q <= '0;
      tile_col_q <= '0;
      tile_vld_q <= 1'b0;
      addr_q <= '0;
      miss_q <= '0;
    end else if (phiL_NCEN) begin
      state_q <= state_d;
      col_idx_q <= col_idx_d;
      name_q <= name_d;
      pat_q <= pat_d;
      col_q <= col_d;
      name_v_q <= name_v_d;
      pat_v_q <= pat_v_d;
      col_v_q <= col_v_d;
      tile_pat_q <= tile_pat_d;
      tile_col_q <= tile_col_d;
      tile_vld_q <= tile_vld_d;
      addr_q <= addr_d;
      miss_q <= miss_d;
    end
  end
  assign vram_req = state_q != IDLE;
  assign vram_addr = addr_q;
  assign tile_pat = tile_pat_q;
  assign tile_col = tile_col_q;
  assign tile_vld = tile_vld_q;
  assign miss_cnt = miss_q;
  assert property (@(posedge phiA) disable iff (!RST_async_n) $onehot0(cpc_m8c));
endmodule

// File: tb/tb_ika9958_tile_fetch_seq.sv
// tb_ika9958_tile_fetch_seq: directed vector table plus hand sequences for the tile fetch sequencer.
module tb_ika9958_tile_fetch_seq;
  logic phiA = 1'b0, RST_async_n = 1'b0, phiL_NCEN = 1'b1;
  logic [3:0] cpc_z = '0, cpc_m16c = '0;
  logic [7:0] cpc_m8c = '0;
  logic tmode = 1'b0, disp_en = 1'b1;
  logic [6:0] nt_base = 7'h01;
  logic [5:0] pg_base = '0;
  logic [11:0] ct_base = '0;
  logic [4:0] tile_row = 5'd3;
  logic [2:0] pix_row = 3'd2;
  logic vram_ack = 1'b0;
  logic [7:0] vram_rdata = '0;
  logic vram_req, tile_vld;
  logic [16:0] vram_addr;
  logic [7:0] tile_pat, tile_col, miss_cnt;
  int n_vec = 0, n_err = 0;
  ika9958_tile_fetch_seq #(.MISS_W(8)) dut (
    .phiA(phiA), .RST_async_n(RST_async_n), .phiL_NCEN(phiL_NCEN), .cpc_z(cpc_z),
    .cpc_m8c(cpc_m8c), .cpc_m16c(cpc_m16c), .tmode(tmode), .disp_en(disp_en),
    .nt_base(nt_base), .pg_base(pg_base), .ct_base(ct_base), .tile_row(tile_row),
    .pix_row(pix_row), .vram_ack(vram_ack), .vram_rdata(vram_rdata), .vram_req(vram_req),
    .vram_addr(vram_addr), .tile_pat(tile_pat), .tile_col(tile_col), .tile_vld(tile_vld),
    .miss_cnt(miss_cnt)
  );
  always #5 phiA = ~phiA;
  typedef struct {
    logic [7:0] m8c; logic ack; logic [7:0] rd; logic tm;
    logic ereq; logic [16:0] eaddr; logic evld; logic [7:0] epat, ecol, emiss;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(logic [7:0] m8c, logic ack, logic [7:0] rd, logic tm, logic ereq,
                              logic [16:0] eaddr, logic evld, logic [7:0] epat, logic [7:0] ecol, logic [7:0] emiss);
    vec_t v;
    v.m8c = m8c; v.ack = ack; v.rd = rd; v.tm = tm; v.ereq = ereq; v.eaddr = eaddr;
    v.evld = evld; v.epat = epat; v.ecol = ecol; v.emiss = emiss;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic step(input logic [7:0] m8c, input logic ack, input logic [7:0] rd);
    cpc_m8c = m8c;
    vram_ack = ack;
    vram_rdata = rd;
    @(posedge phiA);
    #1;
    cpc_m8c = '0;
    vram_ack = 1'b0;
  endtask
  initial begin
    // graphics tile, text tile, missed-name tile, then end-of-group abandon and same-edge ack+start
    tbl.push_back(mk(8'h01,0,8'h00,0, 1,17'h00460,0,8'h00,8'h00,0));
    tbl.push_back(mk(8'h00,1,8'h41,0, 0,17'h00460,0,8'h00,8'h00,0));
    tbl.push_back(mk(8'h04,0,8'h00,0, 1,17'h0020A,0,8'h00,8'h00,0));
    tbl.push_back(mk(8'h00,1,8'hAA,0, 0,17'h0020A,0,8'h00,8'h00,0));
    tbl.push_back(mk(8'h10,0,8'h00,0, 1,17'h00008,0,8'h00,8'h00,0));
    tbl.push_back(mk(8'h00,1,8'hF1,0, 0,17'h00008,0,8'h00,8'h00,0));
    tbl.push_back(mk(8'h00,0,8'h00,0, 0,17'h00008,0,8'h00,8'h00,0));
    tbl.push_back(mk(8'h80,0,8'h00,0, 0,17'h00008,1,8'hAA,8'hF1,0));
    tbl.push_back(mk(8'h01,0,8'h00,1, 1,17'h00461,0,8'hAA,8'hF1,0));
    tbl.push_back(mk(8'h00,1,8'h41,1, 0,17'h00461,0,8'hAA,8'hF1,0));
    tbl.push_back(mk(8'h04,0,8'h00,1, 1,17'h0020A,0,8'hAA,8'hF1,0));
    tbl.push_back(mk(8'h00,1,8'h55,1, 0,17'h0020A,0,8'hAA,8'hF1,0));
    tbl.push_back(mk(8'h10,0,8'h00,1, 0,17'h0020A,0,8'hAA,8'hF1,0));
    tbl.push_back(mk(8'h00,1,8'hF1,1, 0,17'h0020A,0,8'hAA,8'hF1,0));
    tbl.push_back(mk(8'h00,0,8'h00,1, 0,17'h0020A,0,8'hAA,8'hF1,0));
    tbl.push_back(mk(8'h80,0,8'h00,1, 0,17'h0020A,1,8'h55,8'h00,0));
    tbl.push_back(mk(8'h01,0,8'h00,0, 1,17'h00462,0,8'h55,8'h00,0));
    tbl.push_back(mk(8'h00,0,8'h00,0, 1,17'h00462,0,8'h55,8'h00,0));
    tbl.push_back(mk(8'h04,0,8'h00,0, 1,17'h0020A,0,8'h55,8'h00,1));
    tbl.push_back(mk(8'h00,1,8'h77,0, 0,17'h0020A,0,8'h55,8'h00,1));
    tbl.push_back(mk(8'h10,0,8'h00,0, 1,17'h00008,0,8'h55,8'h00,1));
    tbl.push_back(mk(8'h00,1,8'h33,0, 0,17'h00008,0,8'h55,8'h00,1));
    tbl.push_back(mk(8'h00,0,8'h00,0, 0,17'h00008,0,8'h55,8'h00,1));
    tbl.push_back(mk(8'h80,0,8'h00,0, 0,17'h00008,0,8'h55,8'h00,1));
    tbl.push_back(mk(8'h01,0,8'h00,0, 1,17'h00462,0,8'h55,8'h00,1));
    tbl.push_back(mk(8'h80,0,8'h00,0, 0,17'h00462,0,8'h55,8'h00,2));
    tbl.push_back(mk(8'h01,0,8'h00,0, 1,17'h00462,0,8'h55,8'h00,2));
    tbl.push_back(mk(8'h04,1,8'h10,0, 1,17'h00082,0,8'h55,8'h00,2));
    tbl.push_back(mk(8'h00,1,8'h99,0, 0,17'h00082,0,8'h55,8'h00,2));
    repeat (2) @(posedge phiA);
    #1;
    chk("rst.req", vram_req, 0);
    chk("rst.addr", vram_addr, 0);
    chk("rst.vld", tile_vld, 0);
    chk("rst.pat", tile_pat, 0);
    chk("rst.col", tile_col, 0);
    chk("rst.miss", miss_cnt, 0);
    RST_async_n = 1'b1;
    foreach (tbl[i]) begin
      tmode = tbl[i].tm;
      step(tbl[i].m8c, tbl[i].ack, tbl[i].rd);
      chk($sformatf("v%0d.req", i), vram_req, tbl[i].ereq);
      chk($sformatf("v%0d.addr", i), vram_addr, tbl[i].eaddr);
      chk($sformatf("v%0d.vld", i), tile_vld, tbl[i].evld);
      chk($sformatf("v%0d.pat", i), tile_pat, tbl[i].epat);
      chk($sformatf("v%0d.col", i), tile_col, tbl[i].ecol);
      chk($sformatf("v%0d.miss", i), miss_cnt, tbl[i].emiss);
    end
    tmode = 1'b0;
    step(8'h04, 0, 8'h00);
    chk("de.pat_req", vram_req, 1);
    chk("de.pat_addr", vram_addr, 17'h00082);
    disp_en = 1'b0;
    step(8'h00, 0, 8'h00);
    chk("de.req_low", vram_req, 0);
    chk("de.miss", miss_cnt, 2);
    disp_en = 1'b1;
    step(8'h01, 0, 8'h00);
    chk("de.col_idx0", vram_addr, 17'h00460);
    chk("de.name_req", vram_req, 1);
    RST_async_n = 1'b0;
    #1;
    chk("amr.req", vram_req, 0);
    chk("amr.addr", vram_addr, 0);
    chk("amr.pat", tile_pat, 0);
    chk("amr.miss", miss_cnt, 0);
    #2;
    RST_async_n = 1'b1;
    for (int k = 0; k <= 32; k++) begin
      step(8'h01, 0, 8'h00);
      chk($sformatf("wrap%0d.addr", k), vram_addr, 17'h00460 | 17'(k % 32));
      step(8'h00, 1, 8'h41);
      chk($sformatf("wrap%0d.req", k), vram_req, 0);
    end
    step(8'h04, 0, 8'h00);
    step(8'h00, 1, 8'hC3);
    step(8'h10, 0, 8'h00);
    step(8'h00, 1, 8'h3C);
    step(8'h80, 0, 8'h00);
    chk("gt.vld", tile_vld, 1);
    chk("gt.pat", tile_pat, 8'hC3);
    chk("gt.col", tile_col, 8'h3C);
    phiL_NCEN = 1'b0;
    step(8'h01, 1, 8'hFF);
    chk("ncen.vld_hold", tile_vld, 1);
    chk("ncen.req", vram_req, 0);
    phiL_NCEN = 1'b1;
    step(8'h00, 0, 8'h00);
    chk("ncen.vld_fall", tile_vld, 0);
    chk("ncen.req2", vram_req, 0);
    for (int i = 1; i <= 300; i++) begin
      step(8'h01, 0, 8'h00);
      if (i == 200) chk("sat.mid", miss_cnt, 199);
    end
    chk("sat.final", miss_cnt, 255);
    chk("sat.req", vram_req, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
